// File: rtl/bram_pkg.sv
// bram_pkg -- shared types and constants for the true dual-port byte-enable BRAM.
//
// Contents:
//   bram_wmode_e  : per-port same-port write/read policy
//                   (BRAM_READ_FIRST, BRAM_WRITE_FIRST, BRAM_NO_CHANGE)
//   BRAM_BYTE_W   : width of one byte lane covered by a single write-enable bit
//   BRAM_NPORT    : number of access ports (A = 0, B = 1)
package bram_pkg;

  typedef enum logic [1:0] {
    BRAM_READ_FIRST  = 2'd0,
    BRAM_WRITE_FIRST = 2'd1,
    BRAM_NO_CHANGE   = 2'd2
  } bram_wmode_e;

  localparam int BRAM_BYTE_W = 8;
  localparam int BRAM_NPORT  = 2;

endpackage

// File: rtl/bram_out_stage.sv
// bram_out_stage -- per-port read result path: rvalid tracking, optional
// output register and output reset.
//
// Optional feature: define BRAM_OUT_REG_EN to add one output register
// (read latency 2); otherwise the output is the array read register itself
// (read latency 1).
//
// Ports:
//   clk_i    : clock, rising edge
//   rstn_i   : synchronous active-low reset; clears valid stages and output data
//   acc_i    : this cycle's access produces a read result
//   rdata_i  : array read register contents
//   data_o   : read data presented to the port
//   rvalid_o : one-cycle pulse per produced result
module bram_out_stage
  import bram_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              acc_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] data_o,
  output logic              rvalid_o
);

`ifdef BRAM_OUT_REG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  // vld_pipe[0] is the access itself, vld_pipe[k] marks a result k edges old.
  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;

  assign vld_pipe = {vld_q, acc_i};

  always_ff @(posedge clk_i) begin
    if (!rstn_i) vld_q <= '0;
    else         vld_q <= vld_pipe[STAGES-1:0];
  end

`ifdef BRAM_OUT_REG_EN
  logic [DATA_W-1:0] dout_q;

  // Only move forward when the read register holds a fresh result, so the
  // port output stays put across idle and NO_CHANGE-write cycles.
  always_ff @(posedge clk_i) begin
    if (!rstn_i)          dout_q <= '0;
    else if (vld_pipe[1]) dout_q <= rdata_i;
  end

  assign data_o = dout_q;
`else
  assign data_o = rdata_i;
`endif

  assign rvalid_o = vld_pipe[STAGES];

endmodule

// File: rtl/bram_tdp_be.sv
// bram_tdp_be -- true dual-port block RAM with per-byte write enables.
//
// Both ports are fully independent and may access any address every cycle.
// en=1/we=0 is a read, en=1 with any we bit is a write. The same-port result
// of a write follows WRITE_MODE_x (old word, merged new word, or nothing).
// Cross-port write/read of one address returns the old word to the reader;
// write/write collisions give port A its enabled bytes and port B the rest of
// its enabled bytes.
//
// Optional feature: BRAM_OUT_REG_EN adds an output register per port (L=2).
//
// Ports (x = a, b):
//   clk_i, rstn_i : clock, synchronous active-low reset (memory not cleared)
//   x_en_i        : access enable
//   x_we_i        : byte write enables, bit k -> data bits [8k+7:8k]
//   x_addr_i      : word address
//   x_data_i      : write data
//   x_data_o      : read data
//   x_rvalid_o    : x_data_o holds a new result this cycle
module bram_tdp_be
  import bram_pkg::*;
#(
  parameter int          DATA_W       = 32,
  parameter int          ADDR_W       = 10,
  parameter bram_wmode_e WRITE_MODE_A = BRAM_READ_FIRST,
  parameter bram_wmode_e WRITE_MODE_B = BRAM_READ_FIRST
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     a_en_i,
  input  logic [DATA_W/8-1:0]      a_we_i,
  input  logic [ADDR_W-1:0]        a_addr_i,
  input  logic [DATA_W-1:0]        a_data_i,
  output logic [DATA_W-1:0]        a_data_o,
  output logic                     a_rvalid_o,
  input  logic                     b_en_i,
  input  logic [DATA_W/8-1:0]      b_we_i,
  input  logic [ADDR_W-1:0]        b_addr_i,
  input  logic [DATA_W-1:0]        b_data_i,
  output logic [DATA_W-1:0]        b_data_o,
  output logic                     b_rvalid_o
);

  localparam int NB    = DATA_W / BRAM_BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;

  typedef struct packed {
    logic              en;
    logic [NB-1:0]     we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t [BRAM_NPORT-1:0]              req;
  logic [BRAM_NPORT-1:0][NB-1:0]      we_eff;
  logic [BRAM_NPORT-1:0]              wr;
  logic [BRAM_NPORT-1:0]              acc;
  logic [BRAM_NPORT-1:0][DATA_W-1:0]  dout;
  logic [BRAM_NPORT-1:0]              rvld;
  logic                               same_addr;

  logic [DATA_W-1:0] mem [DEPTH];

  assign req[0] = {a_en_i, a_we_i, a_addr_i, a_data_i};
  assign req[1] = {b_en_i, b_we_i, b_addr_i, b_data_i};

  assign same_addr = (req[0].addr == req[1].addr);

  for (genvar p = 0; p < BRAM_NPORT; p++) begin : g_port
    localparam bram_wmode_e MODE = (p == 0) ? WRITE_MODE_A : WRITE_MODE_B;

    logic [NB-1:0]     wmask;
    logic [DATA_W-1:0] old_w;
    logic [DATA_W-1:0] merged_w;
    logic [DATA_W-1:0] rd_q;

    // Writes are ignored while reset is held.
    assign we_eff[p] = req[p].we & {NB{rstn_i & req[p].en}};
    assign wr[p]     = |we_eff[p];
    // NO_CHANGE writes produce no result; everything else enabled does.
    assign acc[p]    = rstn_i & req[p].en & ~(wr[p] & (MODE == BRAM_NO_CHANGE));

    // Port B yields to A on bytes both ports write at the same address, so
    // the final word does not depend on which write block runs last.
    if (p == 0) begin : g_mask
      assign wmask = we_eff[0];
    end else begin : g_mask
      assign wmask = we_eff[1] & ~(same_addr ? we_eff[0] : '0);
    end

    always @(posedge clk_i) begin
      for (int k = 0; k < NB; k++)
        if (wmask[k])
          mem[req[p].addr][k*BRAM_BYTE_W +: BRAM_BYTE_W] <=
            req[p].wdata[k*BRAM_BYTE_W +: BRAM_BYTE_W];
    end

    assign old_w = mem[req[p].addr];

    // Own-port view of the written word: new bytes where we=1, old elsewhere.
    always_comb begin
      merged_w = old_w;
      for (int k = 0; k < NB; k++)
        if (req[p].we[k])
          merged_w[k*BRAM_BYTE_W +: BRAM_BYTE_W] =
            req[p].wdata[k*BRAM_BYTE_W +: BRAM_BYTE_W];
    end

    // Array read register. Reads see pre-edge contents, which gives
    // READ_FIRST and old-word cross-port behaviour for free.
    always_ff @(posedge clk_i) begin
      if (!rstn_i)
        rd_q <= '0;
      else if (acc[p])
        rd_q <= (MODE == BRAM_WRITE_FIRST && wr[p]) ? merged_w : old_w;
    end

    bram_out_stage #(
      .DATA_W (DATA_W)
    ) u_out (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .acc_i    (acc[p]),
      .rdata_i  (rd_q),
      .data_o   (dout[p]),
      .rvalid_o (rvld[p])
    );
  end

  assign a_data_o   = dout[0];
  assign a_rvalid_o = rvld[0];
  assign b_data_o   = dout[1];
  assign b_rvalid_o = rvld[1];

endmodule

// File: doc/bram_tdp_be.md
BRAM_TDP_BE -- requirements
Module: bram_tdp_be

Interface
REQ-001 SHALL have parameter DATA_W, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 10: address bits; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter WRITE_MODE_A, default BRAM_READ_FIRST: port A same-port write/read policy.
REQ-004 SHALL have parameter WRITE_MODE_B, default BRAM_READ_FIRST: port B same-port write/read policy.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all ports synchronous to its rising edge.
REQ-006 SHALL have port rstn_i, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port a_en_i, input, 1: port A access enable.
REQ-008 SHALL have port a_we_i, input, DATA_W/8: port A byte write enables, bit k covers bits [8k+7:8k].
REQ-009 SHALL have port a_addr_i, input, ADDR_W: port A address.
REQ-010 SHALL have port a_data_i, input, DATA_W: port A write data.
REQ-011 SHALL have port a_data_o, output, DATA_W: port A read data.
REQ-012 SHALL have port a_rvalid_o, output, 1: a_data_o holds new read data this cycle.
REQ-013 SHALL have port B ports b_en_i, b_we_i, b_addr_i, b_data_i, b_data_o, b_rvalid_o, identical to port A.

Function
REQ-014 SHALL keep ports A and B fully independent; any port accesses any address each cycle.
REQ-015 SHALL treat a cycle with en=1 and we=0 as a read, and en=1 with any we bit set as a write.
REQ-016 SHALL update only the enabled bytes of the addressed word on a write; other bytes are retained.
REQ-017 SHALL set read latency L = 1 cycle from the enabled edge to data_o/rvalid_o without BRAM_OUT_REG_EN, and L = 2 with it.
REQ-018 BRAM_READ_FIRST: a write cycle SHALL return the word's old contents with rvalid=1.
REQ-019 BRAM_WRITE_FIRST: a write cycle SHALL return the merged new word, i.e. new bytes where we=1 and old bytes elsewhere, with rvalid=1.
REQ-020 BRAM_NO_CHANGE: a write cycle SHALL leave data_o unchanged and SHALL produce no rvalid pulse.
REQ-021 SHALL hold data_o stable when en=0, and rvalid_o SHALL be 0 on those result slots.
REQ-022 SHALL pulse rvalid_o for exactly one cycle per producing access; back-to-back accesses SHALL yield back-to-back pulses.
REQ-023 On a cross-port collision where one port writes and the other reads the same address in the same cycle, the reading port SHALL return the old word.
REQ-024 On a write-write collision to the same address, port A's enabled bytes SHALL win.
REQ-025 On a write-write collision, port B's bytes not written by A SHALL be written.
REQ-026 Address wrap-around is not applicable, since every ADDR_W value is a valid location.

Reset
REQ-027 While rstn_i=0 at a clock edge, a_data_o, b_data_o, a_rvalid_o and b_rvalid_o SHALL be 0 after that edge.
REQ-028 While rstn_i=0, pipeline valid stages SHALL be cleared.
REQ-029 Reset SHALL NOT alter memory contents.
REQ-030 Writes presented during reset SHALL be ignored.
REQ-031 A read in flight when reset asserts SHALL be dropped, with no rvalid pulse after reset release.

Configuration
REQ-032 BRAM_OUT_REG_EN defined: each port SHALL add one output register stage, giving L=2.
REQ-033 With BRAM_OUT_REG_EN defined, that output register stage SHALL be reset per REQ-027 and SHALL advance only when the preceding stage holds valid data.
REQ-034 BRAM_OUT_REG_EN undefined: L=1 and the output is driven directly from the array read register.

Structure
REQ-035 Package bram_pkg SHALL hold the bram_wmode_e enum {BRAM_READ_FIRST, BRAM_WRITE_FIRST, BRAM_NO_CHANGE}.
REQ-036 Package bram_pkg SHALL hold the byte-width constant BRAM_BYTE_W=8.
REQ-037 SHALL instantiate sub-module bram_out_stage once per port, holding the optional register stage, rvalid tracking and reset of the outputs.
REQ-038 The array SHALL be a single memory written from one always block per port, inferable as true dual-port block RAM.

Verification
REQ-039 Reset, then A writes addr 5 = 0xDEADBEEF with we=1111; A reads addr 5 -> a_data_o=0xDEADBEEF and a_rvalid_o=1 exactly L cycles later.
REQ-040 READ_FIRST A: addr 5 holds 0xDEADBEEF; write 0x11223344 with we=0011 -> returns 0xDEADBEEF; next read returns 0xDEAD3344.
REQ-041 WRITE_FIRST B under the same stimulus -> returns 0xDEAD3344 on the write cycle; NO_CHANGE -> no rvalid, and data_o keeps its prior value.
REQ-042 Same cycle, A writes addr 7 = 0xAAAAAAAA, we=1100, while B writes 0x55555555, we=1111 -> addr 7 reads 0xAAAA5555. A second case: A writes and B reads addr 7 in the same cycle -> B returns the old word.
REQ-043 Issue reads on both ports every cycle for 16 cycles at addr 0..15 -> 16 consecutive rvalid pulses per port with in-order data.
REQ-044 Assert rstn_i=0 in the cycle after a read issues -> no rvalid pulse and outputs 0; memory contents verified intact after release.
